rol_6_bit: RTL and testbench

Registered 6-bit rotate-left-through-carry unit for the 6-bit CPU ALU. It treats the carry-in and operand as one 7-bit ring, `{cf_prev, a}`, and rotates it left by a count taken from operand `b`. It then registers the 6-bit result, the new carry and the sign/zero flags. It sits beside the other ALU shift/rotate blocks, and the ALU result/flag mux selects its outputs.

---
 rtl/rol_6_bit.sv | 75 +++++++
 tb/tb_rol_6_bit.sv | 126 ++++++++++++
 2 files changed

// File: rtl/rol_6_bit.sv
// Rotate-left-through-carry of the 7-bit ring {cf_prev, a} by (b mod 7), with registered result and flags.
// Latency is 1 cycle and throughput is one operation per cycle. There is no backpressure: in_valid captures unconditionally.
module rol_6_bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [5:0] a,
  input  logic [5:0] b,
  input  logic       cf_prev,
  output logic [5:0] r,
  output logic       cf,
  output logic       sf,
  output logic       zf,
  output logic       out_valid
);

  logic [3:0] w_sum1;
  logic [3:0] w_sum2;
  logic [3:0] w_sum2_m7;
  logic [2:0] w_n;
  logic [6:0] w_ring;
  logic [6:0] w_rot;

  logic [5:0] r_res;
  logic       r_cf;
  logic       r_sf;
  logic       r_zf;
  logic       r_vld;

  // Because 8 == 1 (mod 7), the octal digits of b can be folded together. Two folds leave a value of 0..8.
  assign w_sum1    = {1'b0, b[5:3]} + {1'b0, b[2:0]};
  assign w_sum2    = {3'b000, w_sum1[3]} + {1'b0, w_sum1[2:0]};
  assign w_sum2_m7 = w_sum2 - 4'd7;
  assign w_n       = (w_sum2 >= 4'd7) ? w_sum2_m7[2:0] : w_sum2[2:0];

  assign w_ring = {cf_prev, a};

  always_comb begin
    w_rot = w_ring;
    case (w_n)
      3'd1:    w_rot = {w_ring[5:0], w_ring[6]};
      3'd2:    w_rot = {w_ring[4:0], w_ring[6:5]};
      3'd3:    w_rot = {w_ring[3:0], w_ring[6:4]};
      3'd4:    w_rot = {w_ring[2:0], w_ring[6:3]};
      3'd5:    w_rot = {w_ring[1:0], w_ring[6:2]};
      3'd6:    w_rot = {w_ring[0],   w_ring[6:1]};
      default: w_rot = w_ring;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res <= 6'd0;
      r_cf  <= 1'b0;
      r_sf  <= 1'b0;
      r_zf  <= 1'b0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= in_valid;
      if (in_valid) begin
        r_res <= w_rot[5:0];
        r_cf  <= w_rot[6];
        r_sf  <= w_rot[5];
        r_zf  <= ~|w_rot[5:0];
      end
    end
  end

  assign r         = r_res;
  assign cf        = r_cf;
  assign sf        = r_sf;
  assign zf        = r_zf;
  assign out_valid = r_vld;

endmodule

// File: tb/tb_rol_6_bit.sv
// Directed and random checks of rol_6_bit against an integer-arithmetic model of the ring rotate.
module tb_rol_6_bit;
  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [5:0] a;
  logic [5:0] b;
  logic       cf_prev;
  logic [5:0] r;
  logic       cf;
  logic       sf;
  logic       zf;
  logic       out_valid;

  int checks = 0;
  int errors = 0;

  // Expected output state, packed as {out_valid, cf, sf, zf, r}.
  logic [9:0] exp_state;

  rol_6_bit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cf_prev(cf_prev),
    .r(r), .cf(cf), .sf(sf), .zf(zf), .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] model(input int cp, input int av, input int bv);
    int n, v, rot, res;
    n   = bv % 7;
    v   = cp * 64 + av;
    rot = ((v << n) | (v >> (7 - n))) % 128;
    res = rot % 64;
    return {1'b1, (rot >= 64) ? 1'b1 : 1'b0, (res >= 32) ? 1'b1 : 1'b0,
            (res == 0) ? 1'b1 : 1'b0, 6'(res)};
  endfunction

  task automatic check(input string tag, input logic [9:0] expv);
    logic [9:0] obs;
    obs = {out_valid, cf, sf, zf, r};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed {vld,cf,sf,zf,r}=%b expected %b", tag, obs, expv);
    end
  endtask

  // Apply one capture at the next negedge, then sample 1ns after the following posedge.
  task automatic op(input string tag, input logic cp, input logic [5:0] av, input logic [5:0] bv,
                    input logic [9:0] expv);
    @(negedge clk);
    in_valid = 1'b1; cf_prev = cp; a = av; b = bv;
    @(posedge clk); #1;
    check(tag, expv);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = 6'd0; b = 6'd0; cf_prev = 1'b0;
    #2;
    check("reset_state", 10'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", 10'b0);

    op("identity",      1'b1, 6'b010101, 6'b000000, {1'b1, 1'b1, 1'b0, 1'b0, 6'b010101});
    op("rot1_carry_in", 1'b1, 6'b010101, 6'b000001, {1'b1, 1'b0, 1'b1, 1'b0, 6'b101011});
    op("carry_out",     1'b0, 6'b111100, 6'b000001, {1'b1, 1'b1, 1'b1, 1'b0, 6'b111000});
    op("mod7_n5",       1'b0, 6'b100101, 6'b001100, {1'b1, 1'b0, 1'b1, 1'b0, 6'b101001});
    op("mod7_n0",       1'b0, 6'b100101, 6'b000111, {1'b1, 1'b0, 1'b1, 1'b0, 6'b100101});
    op("zf_clear",      1'b1, 6'b000000, 6'b000001, {1'b1, 1'b0, 1'b0, 1'b0, 6'b000001});
    op("zf_set",        1'b0, 6'b000000, 6'b101101, {1'b1, 1'b0, 1'b0, 1'b1, 6'b000000});
    op("b63_n0",        1'b1, 6'b000011, 6'b111111, {1'b1, 1'b1, 1'b0, 1'b0, 6'b000011});
    op("rot6",          1'b1, 6'b000000, 6'b000110, {1'b1, 1'b0, 1'b1, 1'b0, 6'b100000});

    // Hold: the last capture must persist while in_valid is low, with out_valid cleared.
    op("hold_capture",  1'b0, 6'b110011, 6'b000010, model(0, 51, 2));
    exp_state = model(0, 51, 2);
    exp_state[9] = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; a = 6'h2A; b = 6'h05; cf_prev = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("hold_%0d", i), exp_state);
    end

    // Mid-cycle reset: a pending capture is discarded and outputs clear without a clock edge.
    @(negedge clk);
    in_valid = 1'b1; a = 6'h3F; b = 6'h01; cf_prev = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("async_reset", 10'b0);
    @(posedge clk); #1;
    check("reset_held_edge", 10'b0);
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("no_capture_after_reset", 10'b0);

    // Random back-to-back traffic with random gaps.
    exp_state = 10'b0;
    for (int i = 0; i < 300; i++) begin
      logic       v;
      logic       cp;
      logic [5:0] av, bv;
      v  = ($urandom_range(0, 3) != 0);
      cp = 1'($urandom_range(0, 1));
      av = 6'($urandom_range(0, 63));
      bv = 6'($urandom_range(0, 63));
      @(negedge clk);
      in_valid = v; cf_prev = cp; a = av; b = bv;
      if (v) exp_state = model(int'(cp), int'(av), int'(bv));
      else   exp_state[9] = 1'b0;
      @(posedge clk); #1;
      check($sformatf("rand_%0d", i), exp_state);
    end

    @(negedge clk); in_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
